// File: rtl/booth_share_ctrl.sv
// Round-robin front end that time-shares one sequential radix-2 Booth multiplier
// among N_REQ requesters and returns the product tagged with the owner's index.
module booth_share_ctrl #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [2*WIDTH-1:0]       y,
  output logic                     y_valid,
  output logic [ID_W-1:0]          y_id
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                        state, nstate;
  logic [ID_W-1:0]               ptr, win, win_lo, win_hi, id;
  logic                          hi_found, accept;
  logic [CNT_W-1:0]              count;
  logic [N_REQ-1:0][WIDTH-1:0]   a_arr, b_arr;
  logic [WIDTH:0]                acc, mext, sum;
  logic [WIDTH-1:0]              q;
  logic                          q1;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_unpack
      assign a_arr[g] = a_in[g*WIDTH +: WIDTH];
      assign b_arr[g] = b_in[g*WIDTH +: WIDTH];
    end
  endgenerate

  // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    hi_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = ID_W'(i);
        if (i >= int'(ptr)) begin
          win_hi   = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? win_hi : win_lo;
  end

  assign accept = (state == IDLE) && (|req);

  // Booth recode of {Q[0],Q_1}; acc carries one guard bit so -2**(WIDTH-1) never overflows.
  always_comb begin
    case ({q[0], q1})
      2'b01:   sum = acc + mext;
      2'b10:   sum = acc - mext;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = CALC;
      CALC:    if (count == CNT_W'(WIDTH - 1)) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      id      <= '0;
      count   <= '0;
      acc     <= '0;
      mext    <= '0;
      q       <= '0;
      q1      <= 1'b0;
      gnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      y_id    <= '0;
    end else begin
      gnt     <= '0;
      y_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          mext  <= {a_arr[win][WIDTH-1], a_arr[win]};
          q     <= b_arr[win];
          acc   <= '0;
          q1    <= 1'b0;
          count <= '0;
          id    <= win;
          gnt   <= N_REQ'(1) << win;
          ptr   <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
        end
        CALC: begin
          acc   <= {sum[WIDTH], sum[WIDTH:1]};
          q     <= {sum[0], q[WIDTH-1:1]};
          q1    <= q[0];
          count <= count + CNT_W'(1);
        end
        DONE: begin
          y       <= {acc[WIDTH-1:0], q};
          y_id    <= id;
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_share_ctrl.sv
// Directed bench for booth_share_ctrl: a cycle-level behavioural model checked every
// cycle, plus literal expectations for the specific products and grant orders.
module tb_booth_share_ctrl;
  localparam int WIDTH = 4;
  localparam int N_REQ = 2;
  localparam int ID_W  = 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*WIDTH-1:0] a_in = '0;
  logic [N_REQ*WIDTH-1:0] b_in = '0;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [2*WIDTH-1:0]     y;
  logic                   y_valid;
  logic [ID_W-1:0]        y_id;

  int total = 0;
  int bad   = 0;

  booth_share_ctrl #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .y(y), .y_valid(y_valid), .y_id(y_id)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int                        m_phase;   // 0 = free, k = k cycles since accept
  int                        m_ptr;
  int                        m_win, m_wi;
  logic [N_REQ-1:0]          m_gnt;
  logic                      m_busy, m_yv;
  logic signed [2*WIDTH-1:0] m_prod, m_prod_now;
  logic [2*WIDTH-1:0]        m_y;
  logic [ID_W-1:0]           m_id, m_yid;

  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  always_comb begin
    m_win      = pick(req, m_ptr);
    m_wi       = (m_win < 0) ? 0 : m_win;
    m_prod_now = $signed(a_in[m_wi*WIDTH +: WIDTH]) * $signed(b_in[m_wi*WIDTH +: WIDTH]);
  end

  assign m_busy = (m_phase != 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_ptr <= 0; m_gnt <= '0; m_yv <= 1'b0;
      m_y <= '0; m_yid <= '0; m_id <= '0; m_prod <= '0;
    end else begin
      m_gnt <= '0;
      m_yv  <= 1'b0;
      if (m_phase == 0) begin
        if (m_win >= 0) begin
          m_gnt   <= N_REQ'(1) << m_win;
          m_prod  <= m_prod_now;
          m_id    <= m_win[ID_W-1:0];
          m_ptr   <= (m_win + 1) % N_REQ;
          m_phase <= 1;
        end
      end else if (m_phase == WIDTH + 1) begin
        m_y     <= m_prod;
        m_yid   <= m_id;
        m_yv    <= 1'b1;
        m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc gnt", 64'(gnt), 64'(m_gnt));
    chk("cyc busy", 64'(busy), 64'(m_busy));
    chk("cyc y_valid", 64'(y_valid), 64'(m_yv));
    chk("cyc y", 64'(y), 64'(m_y));
    chk("cyc y_id", 64'(y_id), 64'(m_yid));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for y_valid (bounded) and check latency from gnt, product and owner.
  task automatic wait_y(input string nm, input logic [7:0] ey, input int eid);
    int n = 0;
    for (int c = 1; c <= 20 && n == 0; c++) begin
      tick();
      if (y_valid) n = c;
    end
    chk({nm, " latency"}, 64'(n), 64'(WIDTH + 1));
    chk({nm, " y"}, 64'(y), 64'(ey));
    chk({nm, " y_id"}, 64'(y_id), 64'(eid));
    chk({nm, " busy@yv"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string nm, input int i, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] ey);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
    req = N_REQ'(1) << i;
    tick();
    req = '0;
    chk({nm, " gnt"}, 64'(gnt), 64'(N_REQ'(1) << i));
    wait_y(nm, ey, i);
  endtask

  logic [N_REQ-1:0] gq [8];
  logic [7:0]       yq [8];
  logic [ID_W-1:0]  iq [8];

  initial begin
    int ng, ny;
    rst = 1'b1;
    tick(); tick();
    chk("reset gnt", 64'(gnt), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset y", 64'(y), 64'd0);
    chk("reset y_valid", 64'(y_valid), 64'd0);
    chk("reset y_id", 64'(y_id), 64'd0);
    rst = 1'b0;
    tick();

    run_op("2x5", 0, 4'd2, 4'd5, 8'd10);

    // Reset in the middle of CALC: outputs clear at once, op is dropped.
    a_in[3:0] = 4'd3; b_in[3:0] = 4'd2; req = 2'b01;
    tick();
    req = '0;
    tick(); tick();
    chk("pre-rst busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst y", 64'(y), 64'd0);
    chk("async rst gnt", 64'(gnt), 64'd0);
    chk("async rst y_valid", 64'(y_valid), 64'd0);
    tick();
    rst = 1'b0;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (y_valid) ng++;
    end
    chk("no y after rst", 64'(ng), 64'd0);
    a_in = {4'd0, 4'd2}; b_in = {4'd0, 4'hD}; req = 2'b11;
    tick();
    req = '0;
    chk("ptr0 after rst gnt", 64'(gnt), 64'b01);
    wait_y("2x-3", 8'hFA, 0);

    run_op("-6x5", 1, 4'hA, 4'd5, 8'hE2);
    run_op("-6x-3", 0, 4'hA, 4'hD, 8'd18);
    run_op("0x5", 1, 4'd0, 4'd5, 8'd0);
    run_op("-8x-8", 0, 4'h8, 4'h8, 8'h40);
    run_op("-8x7", 1, 4'h8, 4'd7, 8'hC8);
    run_op("7x7", 0, 4'd7, 4'd7, 8'd49);
    run_op("7x-8", 1, 4'd7, 4'h8, 8'hC8);

    // Both requesters held: grants must alternate starting from requester 0.
    a_in = {4'hE, 4'd3}; b_in = {4'd4, 4'd3}; req = 2'b11;
    ng = 0; ny = 0;
    for (int c = 0; c < 40 && ny < 4; c++) begin
      tick();
      if (gnt != 0 && ng < 8) begin gq[ng] = gnt; ng++; end
      if (y_valid) begin yq[ny] = y; iq[ny] = y_id; ny++; end
    end
    req = '0;
    chk("rr grant count", 64'(ng), 64'd4);
    chk("rr result count", 64'(ny), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("rr gnt", 64'(gq[k]), (k % 2 == 0) ? 64'b01 : 64'b10);
      chk("rr y", 64'(yq[k]), (k % 2 == 0) ? 64'd9 : 64'hF8);
      chk("rr y_id", 64'(iq[k]), 64'(k % 2));
    end
    tick();

    // Requester 1 arrives mid-op with changing operands; granted only after y_valid.
    a_in[3:0] = 4'hD; b_in[3:0] = 4'd2; req = 2'b01;
    tick();
    chk("late gnt0", 64'(gnt), 64'b01);
    req = 2'b10; a_in[7:4] = 4'd1; b_in[7:4] = 4'd3;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("late no gnt1", 64'(gnt[1]), 64'd0);
      a_in[7:4] = 4'(n + 1);
    end
    chk("late y_valid", 64'(y_valid), 64'd1);
    chk("late y0", 64'(y), 64'hFA);
    tick();
    chk("late gnt1", 64'(gnt), 64'b10);
    req = '0; a_in[7:4] = 4'hF;
    wait_y("late 6x3", 8'd18, 1);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
